// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register feeding decode.
// Tracks the PC and the tag of the single in-flight read to a 1-cycle-latency synchronous instruction memory.
module fetch_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = 8'h00,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'hE000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   instr_valid,
    output logic [15:0]            fetch_count
);

    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_fPc;
    logic                   r_fValid;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [PC_WIDTH-1:0]    r_pcOut;
    logic                   r_instrValid;
    logic [15:0]            r_fetchCount;

    logic [PC_WIDTH-1:0]    w_pcPlusOne;
    logic [PC_WIDTH-1:0]    w_targetPlusOne;

    assign w_pcPlusOne     = r_pc + PC_WIDTH'(1);
    assign w_targetPlusOne = branch_target + PC_WIDTH'(1);

    // During a stall the in-flight address is re-issued so its data is still on imem_rdata at release.
    always_comb begin
        imem_addr = r_pc;
        if (branch_taken) begin
            imem_addr = branch_target;
        end else if (stall) begin
            imem_addr = r_fPc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_PC;
            r_fPc        <= RESET_PC;
            r_fValid     <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pcOut      <= '0;
            r_instrValid <= 1'b0;
            r_fetchCount <= '0;
        end else if (branch_taken) begin
            r_pc         <= w_targetPlusOne;
            r_fPc        <= branch_target;
            r_fValid     <= 1'b1;
            r_instr      <= NOP_INSTR;
            r_instrValid <= 1'b0;
        end else if (!stall) begin
            r_pc     <= w_pcPlusOne;
            r_fPc    <= r_pc;
            r_fValid <= 1'b1;
            if (r_fValid) begin
                r_instr      <= imem_rdata;
                r_pcOut      <= r_fPc;
                r_instrValid <= 1'b1;
                r_fetchCount <= r_fetchCount + 16'd1;
            end else begin
                r_instr      <= NOP_INSTR;
                r_instrValid <= 1'b0;
            end
        end
    end

    assign instruction = r_instr;
    assign pc_out      = r_pcOut;
    assign instr_valid = r_instrValid;
    assign fetch_count = r_fetchCount;

endmodule
